// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the arb_mux_n round-robin output multiplexer.
// Optional force-grant ports are enabled in the top by defining ARB_MUX_FORCE_EN.
package arb_mux_pkg;

    localparam int ARB_MAX_N = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/arb_mux_n_rr_pick.sv
// Combinational rotate-priority picker: the first requester at or after 'base'
// (wrapping modulo N) wins.
module rr_pick #(
    parameter  int N     = 3,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] base,
    output logic [N-1:0]     gnt_oh,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] b, input int ofs);
        int s;
        s = int'(b) + ofs;
        if (s >= N) s = s - N;
        return SEL_W'(s);
    endfunction

    always_comb begin
        logic [SEL_W-1:0] idx;
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = wrap_idx(base, i);
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt_oh[idx]  = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N:1 round-robin arbitrated mux with a single registered output stage and valid/ready.
// Define ARB_MUX_FORCE_EN to add force_en/force_sel, which pin the grant to one channel.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 3,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
`ifdef ARB_MUX_FORCE_EN
    ,
    input  logic               force_en,
    input  logic [SEL_W-1:0]   force_sel
`endif
);

    state_e             state_q,    state_d;
    logic [SEL_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_sel_q,  out_sel_d;

    logic [WIDTH-1:0]   chan [N];
    logic [N-1:0]       pick_oh,  gnt_oh;
    logic [SEL_W-1:0]   pick_idx, gnt_idx;
    logic               pick_any, gnt_any;
    logic               rotate, can_load, load;

    rr_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .base    (rr_ptr_q),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        for (int i = 0; i < N; i++) chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    // Grant selection; a forced grant never advances the round-robin pointer.
    always_comb begin
        gnt_oh  = pick_oh;
        gnt_idx = pick_idx;
        gnt_any = pick_any;
        rotate  = 1'b1;
`ifdef ARB_MUX_FORCE_EN
        if (force_en) begin
            gnt_oh  = '0;
            gnt_idx = force_sel;
            gnt_any = 1'b0;
            rotate  = 1'b0;
            if (int'(force_sel) < N && in_valid[force_sel]) begin
                gnt_oh[force_sel] = 1'b1;
                gnt_any           = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        can_load   = (state_q == ST_EMPTY) | out_ready;
        load       = gnt_any & can_load & ~rst;
        in_ready   = load ? gnt_oh : '0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        if (load) begin
            state_d    = ST_FULL;
            out_data_d = chan[gnt_idx];
            out_sel_d  = gnt_idx;
            if (rotate)
                rr_ptr_d = (gnt_idx == SEL_W'(N-1)) ? '0 : gnt_idx + 1'b1;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= '0;
            out_data_q <= '0;
            out_sel_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
